// File: rtl/spi_pkg.sv
// Shared constants and types for the SPI frame buffer and its input synchronisers.
// The synchroniser depth is fixed here so every SPI pin sees the same latency.
package spi_pkg;

    localparam int SPI_SYNC_STAGES = 2;

    typedef struct packed {
        logic rise;
        logic fall;
    } spi_edge_t;

endpackage

// File: rtl/spi_input_sync.sv
// Two-flop synchroniser plus a registered edge detector for one asynchronous SPI pin.
// Level is valid SPI_SYNC_STAGES cycles after the pin changes; the edge pulse follows one cycle later.
module spi_input_sync
    import spi_pkg::*;
#(
    parameter logic RST_VAL = 1'b0
) (
    input  logic      i_clk,
    input  logic      i_reset,
    input  logic      i_async,
    output logic      o_level,
    output spi_edge_t o_edge
);

    logic [SPI_SYNC_STAGES-1:0] r_chain;
    logic                       r_prev;
    spi_edge_t                  r_edge;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_chain <= {SPI_SYNC_STAGES{RST_VAL}};
            r_prev  <= RST_VAL;
            r_edge  <= '0;
        end else begin
            r_chain     <= {r_chain[SPI_SYNC_STAGES-2:0], i_async};
            r_prev      <= r_chain[SPI_SYNC_STAGES-1];
            r_edge.rise <= r_chain[SPI_SYNC_STAGES-1] & ~r_prev;
            r_edge.fall <= ~r_chain[SPI_SYNC_STAGES-1] & r_prev;
        end
    end

    assign o_level = r_chain[SPI_SYNC_STAGES-1];
    assign o_edge  = r_edge;

endmodule

// File: rtl/spi_frame_buffer.sv
// SPI peripheral frame buffer: assembles MSB-first words into a DEPTH-entry buffer and shifts tx words out.
// Stored words appear three sys_clk edges after the final sclk high is first sampled; there is no backpressure.
module spi_frame_buffer
    import spi_pkg::*;
#(
    parameter  int WORD_W = 8,
    parameter  int DEPTH  = 4,
    localparam int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic                    sys_clk,
    input  logic                    reset,
    input  logic                    spi_sclk,
    input  logic                    spi_cs_n,
    input  logic                    spi_pico,
    output logic                    spi_poci,
    output logic [DEPTH*WORD_W-1:0] rx_data,
    output logic [CNT_W-1:0]        rx_count,
    output logic                    word_valid,
    output logic                    frame_active,
    output logic                    frame_done,
    output logic                    frame_error,
    output logic [CNT_W-1:0]        tx_index,
    input  logic [WORD_W-1:0]       tx_word
);

    localparam int                BIT_W    = $clog2(WORD_W);
    localparam logic [BIT_W-1:0]  BIT_LAST = BIT_W'(WORD_W - 1);
    localparam logic [CNT_W-1:0]  DEPTH_C  = CNT_W'(DEPTH);

    spi_edge_t   w_sclk_edge;
    spi_edge_t   w_cs_edge;
    spi_edge_t   w_pico_edge_unused;
    logic        w_sclk_lvl_unused;
    logic        w_cs_lvl_unused;
    logic        w_pico;
    logic [WORD_W-1:0] w_rx_next;

    logic [WORD_W-1:0] r_rx_mem [DEPTH];
    logic [WORD_W-2:0] r_rx_shift;
    logic [WORD_W-1:0] r_tx_shift;
    logic [BIT_W-1:0]  r_bit_cnt;
    logic [CNT_W-1:0]  r_rx_count;
    logic [CNT_W-1:0]  r_tx_index;
    logic              r_shift_pending;
    logic              r_frame_active;
    logic              r_frame_done;
    logic              r_frame_error;
    logic              r_word_valid;

    // cs_n resets low so a frame already running at reset release is never picked up mid-way.
    spi_input_sync #(.RST_VAL(1'b0)) u_sync_sclk (
        .i_clk   (sys_clk),
        .i_reset (reset),
        .i_async (spi_sclk),
        .o_level (w_sclk_lvl_unused),
        .o_edge  (w_sclk_edge)
    );

    spi_input_sync #(.RST_VAL(1'b0)) u_sync_cs (
        .i_clk   (sys_clk),
        .i_reset (reset),
        .i_async (spi_cs_n),
        .o_level (w_cs_lvl_unused),
        .o_edge  (w_cs_edge)
    );

    spi_input_sync #(.RST_VAL(1'b0)) u_sync_pico (
        .i_clk   (sys_clk),
        .i_reset (reset),
        .i_async (spi_pico),
        .o_level (w_pico),
        .o_edge  (w_pico_edge_unused)
    );

    assign w_rx_next = {r_rx_shift, w_pico};

    always_ff @(posedge sys_clk) begin
        r_word_valid <= 1'b0;
        r_frame_done <= 1'b0;
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) r_rx_mem[i] <= '0;
            r_rx_shift      <= '0;
            r_tx_shift      <= '0;
            r_bit_cnt       <= '0;
            r_rx_count      <= '0;
            r_tx_index      <= '0;
            r_shift_pending <= 1'b0;
            r_frame_active  <= 1'b0;
            r_frame_error   <= 1'b0;
        end else if (w_cs_edge.fall) begin
            r_frame_active  <= 1'b1;
            r_rx_count      <= '0;
            r_frame_error   <= 1'b0;
            r_bit_cnt       <= '0;
            r_rx_shift      <= '0;
            r_shift_pending <= 1'b0;
            r_tx_shift      <= tx_word;
            r_tx_index      <= CNT_W'(1);
        end else if (w_cs_edge.rise && r_frame_active) begin
            r_frame_active  <= 1'b0;
            r_frame_done    <= 1'b1;
            r_bit_cnt       <= '0;
            r_shift_pending <= 1'b0;
            // Rewind so the caller presents word 0 before the next frame starts.
            r_tx_index      <= '0;
            if (r_bit_cnt != '0) r_frame_error <= 1'b1;
        end else if (r_frame_active && w_sclk_edge.rise) begin
            r_rx_shift      <= w_rx_next[WORD_W-2:0];
            r_shift_pending <= 1'b1;
            if (r_bit_cnt == BIT_LAST) begin
                r_bit_cnt <= '0;
                if (r_rx_count == DEPTH_C) begin
                    r_frame_error <= 1'b1;
                end else begin
                    for (int i = 0; i < DEPTH; i++)
                        if (r_rx_count == CNT_W'(i)) r_rx_mem[i] <= w_rx_next;
                    r_rx_count   <= r_rx_count + CNT_W'(1);
                    r_word_valid <= 1'b1;
                end
            end else begin
                r_bit_cnt <= r_bit_cnt + BIT_W'(1);
            end
        end else if (r_frame_active && w_sclk_edge.fall && r_shift_pending) begin
            r_shift_pending <= 1'b0;
            if (r_bit_cnt == '0) begin
                r_tx_shift <= tx_word;
                if (r_tx_index != DEPTH_C) r_tx_index <= r_tx_index + CNT_W'(1);
            end else begin
                r_tx_shift <= {r_tx_shift[WORD_W-2:0], 1'b0};
            end
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_rx_out
        assign rx_data[g*WORD_W +: WORD_W] = r_rx_mem[g];
    end

    assign spi_poci     = r_frame_active & r_tx_shift[WORD_W-1];
    assign rx_count     = r_rx_count;
    assign word_valid   = r_word_valid;
    assign frame_active = r_frame_active;
    assign frame_done   = r_frame_done;
    assign frame_error  = r_frame_error;
    assign tx_index     = r_tx_index;

endmodule

// File: tb/tb_spi_frame_buffer.sv
// Directed bench for spi_frame_buffer: an 8x4 instance and a 16x2 instance share sclk/pico,
// each with its own cs_n; stored words are scoreboarded against queued expectations.
`timescale 1ns/1ps
module tb_spi_frame_buffer;

    localparam int HP = 60;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst8, rst16, sclk, pico, cs8, cs16;
    logic poci8, poci16;
    logic [31:0] rx8;
    logic [2:0]  cnt8, txi8;
    logic [7:0]  txw8;
    logic        wv8, fa8, fd8, fe8;
    logic [31:0] rx16;
    logic [1:0]  cnt16, txi16;
    logic [15:0] txw16;
    logic        wv16, fa16, fd16, fe16;

    assign txw8  = 8'h80 + {5'd0, txi8};
    assign txw16 = 16'hC3A5;

    spi_frame_buffer #(.WORD_W(8), .DEPTH(4)) dut (
        .sys_clk(clk), .reset(rst8), .spi_sclk(sclk), .spi_cs_n(cs8), .spi_pico(pico),
        .spi_poci(poci8), .rx_data(rx8), .rx_count(cnt8), .word_valid(wv8),
        .frame_active(fa8), .frame_done(fd8), .frame_error(fe8),
        .tx_index(txi8), .tx_word(txw8)
    );

    spi_frame_buffer #(.WORD_W(16), .DEPTH(2)) dut16 (
        .sys_clk(clk), .reset(rst16), .spi_sclk(sclk), .spi_cs_n(cs16), .spi_pico(pico),
        .spi_poci(poci16), .rx_data(rx16), .rx_count(cnt16), .word_valid(wv16),
        .frame_active(fa16), .frame_done(fd16), .frame_error(fe16),
        .tx_index(txi16), .tx_word(txw16)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int wv8_cnt = 0, fd8_cnt = 0, wv16_cnt = 0, fd16_cnt = 0;
    logic [15:0] q8[$];
    logic [15:0] q16[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin : mon
        logic [15:0] e;
        logic [15:0] got;
        if (wv8 === 1'b1) begin
            wv8_cnt++;
            n_tests++;
            assert (q8.size() > 0 && cnt8 != 3'd0) else begin
                n_fail++;
                $error("FAIL sb8_unexpected: observed count %0d queued %0d", cnt8, q8.size());
            end
            if (q8.size() > 0 && cnt8 != 3'd0) begin
                e = q8.pop_front();
                got = {8'h00, rx8[(int'(cnt8) - 1) * 8 +: 8]};
                check("sb8_word", {16'h0, got}, {16'h0, e});
            end
        end
        if (fd8 === 1'b1) fd8_cnt++;
        if (wv16 === 1'b1) begin
            wv16_cnt++;
            n_tests++;
            assert (q16.size() > 0 && cnt16 != 2'd0) else begin
                n_fail++;
                $error("FAIL sb16_unexpected: observed count %0d queued %0d", cnt16, q16.size());
            end
            if (q16.size() > 0 && cnt16 != 2'd0) begin
                e = q16.pop_front();
                got = rx16[(int'(cnt16) - 1) * 16 +: 16];
                check("sb16_word", {16'h0, got}, {16'h0, e});
            end
        end
        if (fd16 === 1'b1) fd16_cnt++;
    end

    // Controller side: drives pico, samples poci just before each rising sclk.
    task automatic spi_word(input logic [15:0] w, input int nbits, input bit mode3,
                            input bit sel16, output logic [15:0] got);
        got = '0;
        for (int i = nbits - 1; i >= 0; i--) begin
            if (mode3) sclk = 1'b0;
            pico = w[i];
            #(HP);
            got = {got[14:0], sel16 ? poci16 : poci8};
            sclk = 1'b1;
            #(HP);
            if (!mode3) sclk = 1'b0;
        end
    endtask

    task automatic cs8_low(input bit mode3);
        sclk = mode3;
        #(HP);
        cs8 = 1'b0;
        #(100);
    endtask

    task automatic cs8_high();
        #(HP);
        cs8 = 1'b1;
        #(200);
    endtask

    initial begin
        logic [15:0] g;
        logic [7:0]  words [4];
        int wv_base, fd_base;
        words = '{8'hA5, 8'h3C, 8'h01, 8'hFF};
        sclk = 1'b0; pico = 1'b0; cs8 = 1'b1; cs16 = 1'b1; rst8 = 1'b1; rst16 = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("rst_rx_data", rx8, 32'h0);
        check("rst_rx_count", {29'h0, cnt8}, 32'h0);
        check("rst_tx_index", {29'h0, txi8}, 32'h0);
        check("rst_flags", {28'h0, wv8, fa8, fd8, fe8}, 32'h0);
        check("rst_poci", {31'h0, poci8}, 32'h0);
        rst8 = 1'b0; rst16 = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        // Mode 0 frame with tx words 0x80+index.
        wv_base = wv8_cnt; fd_base = fd8_cnt;
        cs8_low(1'b0);
        check("m0_active", {31'h0, fa8}, 32'h1);
        for (int k = 0; k < 4; k++) begin
            q8.push_back({8'h00, words[k]});
            spi_word({8'h00, words[k]}, 8, 1'b0, 1'b0, g);
            check("m0_poci", {24'h0, g[7:0]}, 32'h80 + k);
        end
        cs8_high();
        check("m0_rx_data", rx8, 32'hFF013CA5);
        check("m0_rx_count", {29'h0, cnt8}, 32'd4);
        check("m0_wv_pulses", wv8_cnt - wv_base, 32'd4);
        check("m0_done_pulses", fd8_cnt - fd_base, 32'd1);
        check("m0_error", {31'h0, fe8}, 32'h0);
        check("m0_inactive", {31'h0, fa8}, 32'h0);

        // Mode 3 frame: sclk idles high, leading falling edge must not shift.
        wv_base = wv8_cnt; fd_base = fd8_cnt;
        cs8_low(1'b1);
        for (int k = 0; k < 4; k++) begin
            q8.push_back({8'h00, words[k]});
            spi_word({8'h00, words[k]}, 8, 1'b1, 1'b0, g);
            check("m3_poci", {24'h0, g[7:0]}, 32'h80 + k);
        end
        cs8_high();
        sclk = 1'b0;
        check("m3_rx_data", rx8, 32'hFF013CA5);
        check("m3_wv_pulses", wv8_cnt - wv_base, 32'd4);
        check("m3_done_pulses", fd8_cnt - fd_base, 32'd1);
        check("m3_error", {31'h0, fe8}, 32'h0);

        // Overflow: six words into a four-entry buffer.
        wv_base = wv8_cnt;
        cs8_low(1'b0);
        for (int k = 1; k <= 6; k++) begin
            if (k <= 4) q8.push_back(16'(k * 8'h11));
            spi_word(16'(k * 8'h11), 8, 1'b0, 1'b0, g);
        end
        cs8_high();
        check("ovf_rx_count", {29'h0, cnt8}, 32'd4);
        check("ovf_rx_data", rx8, 32'h44332211);
        check("ovf_error", {31'h0, fe8}, 32'h1);
        check("ovf_wv_pulses", wv8_cnt - wv_base, 32'd4);

        // Partial word at frame end.
        fd_base = fd8_cnt;
        cs8_low(1'b0);
        check("part_error_cleared", {31'h0, fe8}, 32'h0);
        q8.push_back(16'h005A);
        spi_word(16'h005A, 8, 1'b0, 1'b0, g);
        spi_word(16'h0005, 3, 1'b0, 1'b0, g);
        cs8_high();
        check("part_rx_count", {29'h0, cnt8}, 32'd1);
        check("part_word0", {24'h0, rx8[7:0]}, 32'h5A);
        check("part_error", {31'h0, fe8}, 32'h1);
        check("part_done_pulses", fd8_cnt - fd_base, 32'd1);

        // Reset mid-frame with cs_n held low through release.
        cs8_low(1'b0);
        q8.push_back(16'h00C7);
        spi_word(16'h00C7, 8, 1'b0, 1'b0, g);
        spi_word(16'h000A, 4, 1'b0, 1'b0, g);
        @(posedge clk); #1;
        rst8 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst8 = 1'b0;
        wv_base = wv8_cnt; fd_base = fd8_cnt;
        check("rstmid_count", {29'h0, cnt8}, 32'd0);
        check("rstmid_active", {31'h0, fa8}, 32'h0);
        spi_word(16'h0096, 8, 1'b0, 1'b0, g);
        #(HP);
        check("rstmid_no_wv", wv8_cnt - wv_base, 32'd0);
        cs8 = 1'b1;
        #(200);
        check("rstmid_no_done", fd8_cnt - fd_base, 32'd0);
        check("rstmid_still_idle", {31'h0, fa8}, 32'h0);
        cs8_low(1'b0);
        q8.push_back(16'h003E);
        spi_word(16'h003E, 8, 1'b0, 1'b0, g);
        cs8_high();
        check("rstmid_fresh_count", {29'h0, cnt8}, 32'd1);
        check("rstmid_fresh_wv", wv8_cnt - wv_base, 32'd1);
        check("rstmid_fresh_done", fd8_cnt - fd_base, 32'd1);
        check("rstmid_fresh_word", {24'h0, rx8[7:0]}, 32'h3E);

        // 16-bit, depth-2 instance.
        sclk = 1'b0;
        #(HP); cs16 = 1'b0; #(100);
        q16.push_back(16'h1234);
        spi_word(16'h1234, 16, 1'b0, 1'b1, g);
        q16.push_back(16'hBEEF);
        spi_word(16'hBEEF, 16, 1'b0, 1'b1, g);
        #(HP); cs16 = 1'b1; #(200);
        check("w16_rx_data", rx16, 32'hBEEF1234);
        check("w16_rx_count", {30'h0, cnt16}, 32'd2);
        check("w16_error", {31'h0, fe16}, 32'h0);
        #(HP); cs16 = 1'b0; #(100);
        q16.push_back(16'h5555);
        spi_word(16'h5555, 16, 1'b0, 1'b1, g);
        #(HP); cs16 = 1'b1; #(200);
        check("w16b_rx_count", {30'h0, cnt16}, 32'd1);
        check("w16b_stale_hi", {16'h0, rx16[31:16]}, 32'hBEEF);
        check("w16b_word0", {16'h0, rx16[15:0]}, 32'h5555);
        check("w16_done_pulses", 32'(fd16_cnt), 32'd2);

        check("sb8_drained", 32'(q8.size()), 32'd0);
        check("sb16_drained", 32'(q16.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_frame_buffer.md
Name: spi_frame_buffer

Overview:
- Parametrised SPI peripheral frame buffer, fully in the sys_clk domain.
- Oversamples and synchronises spi_sclk, spi_cs_n and spi_pico.
- Assembles MSB-first words of WORD_W bits into a DEPTH-entry receive buffer and shifts caller-supplied words out on spi_poci.
- Successor to the single-clock-unsafe byte buffer: adds generic word width and depth, frame start/end strobes, and overflow/partial-word error reporting.
- Sits between the SPI pins and the command decoder that drives the bus-master FSM.

Parameters:
- WORD_W, 8: bits per SPI word (≥2).
- DEPTH, 4: receive words per frame (≥1).
- CNT_W, $clog2(DEPTH+1): width of the word counters (derived, not overridden).

Ports:
- sys_clk  in  1  system clock; must be ≥4× spi_sclk.
- reset  in  1  synchronous, active-high reset.
- spi_sclk  in  1  async SPI clock, mode 0 or mode 3.
- spi_cs_n  in  1  async chip select, active low.
- spi_pico  in  1  async controller→peripheral data.
- spi_poci  out  1  peripheral→controller data.
- rx_data  out  DEPTH*WORD_W  received words; word i occupies [i*WORD_W +: WORD_W].
- rx_count  out  CNT_W  words stored this frame; saturates at DEPTH.
- word_valid  out  1  1-cycle pulse when a word is stored.
- frame_active  out  1  high between detected cs_n fall and cs_n rise.
- frame_done  out  1  1-cycle pulse on cs_n rise of an active frame.
- frame_error  out  1  sticky per frame: overflow, or partial word at frame end.
- tx_index  out  CNT_W  index of the next tx word to be loaded.
- tx_word  in  WORD_W  word to transmit at tx_index; sampled on load.

Behaviour:
- Clock and reset: one clock, sys_clk. Reset is synchronous and active-high.
- Synchronisers: 2-flop chain on each SPI input, plus one registered copy for edge detect.
  - Reset values: sclk sync = 0, pico sync = 0, cs_n sync = 0 (treated as asserted). A frame in progress at reset release is therefore ignored until cs_n goes high and then low again.
- Reset values of outputs: rx_data = 0, rx_count = 0, tx_index = 0, word_valid = 0, frame_done = 0, frame_active = 0, frame_error = 0, spi_poci = 0. Bit counter and shift registers are cleared.
- Frame start (synchronised cs_n falling edge):
  - frame_active = 1; rx_count = 0; frame_error = 0; bit count = 0.
  - tx shift reg loads tx_word at tx_index 0; tx_index becomes 1.
  - rx_data is not cleared; entries at or above rx_count are stale.
- Rising sclk while frame_active:
  - Shift the synchronised pico into the rx shift reg (MSB first); bit count increments; shift_pending = 1.
  - When bit count reaches WORD_W:
    - If rx_count < DEPTH: write the word to rx_data[rx_count], increment rx_count, pulse word_valid.
    - If rx_count = DEPTH: discard the word and set frame_error; word_valid still does not pulse.
    - Bit count returns to 0 in either case.
- Latency: rx_data, rx_count and word_valid update on sys_clk edge N+3, where N is the edge whose first sync flop captures the final sclk high.
- Falling sclk while frame_active, with shift_pending = 1:
  - If bit count = 0: load tx_word and increment tx_index (saturating at DEPTH).
  - Otherwise: shift the tx reg left.
  - Clear shift_pending.
  - A falling edge with shift_pending = 0 does nothing. This covers the mode-3 leading edge.
- spi_poci = tx shift reg MSB while frame_active, else 0.
- Frame end (synchronised cs_n rising edge while frame_active):
  - frame_done pulses; frame_active = 0.
  - If bit count ≠ 0, set frame_error and discard the partial word.
  - rx_count, rx_data and frame_error hold until the next frame start.
- Priority: a cs_n edge detected in the same cycle as an sclk edge wins; the sclk edge is ignored. sclk edges are ignored while frame_active = 0.
- Reset asserted mid-frame: all state returns to reset values immediately; no frame_done is generated.

Decomposition:
- Package spi_pkg: SPI_SYNC_STAGES = 2, and a typedef for the edge-detect struct {rise, fall}.
- Sub-module spi_input_sync: 2-flop synchroniser plus edge detector, with reset value as a parameter. Instantiated 3× (sclk, cs_n, pico; pico uses the level output only).
- Everything else (counters, shift registers, buffer) lives in spi_frame_buffer.

Test Plan:
- Mode 0, DEPTH=4, WORD_W=8: send 0xA5, 0x3C, 0x01, 0xFF, then raise cs_n → rx_data = {FF,01,3C,A5}, rx_count = 4, 4 word_valid pulses, frame_done once, frame_error = 0.
- Mode 3, same frame with tx_word = 0x80+tx_index → controller receives 0x80, 0x81, 0x82, 0x83, and no bit is shifted on the leading falling edge.
- Overflow: 6 words with DEPTH=4 → rx_count = 4, words 5–6 discarded, frame_error = 1, exactly 4 word_valid pulses.
- Partial word: 1 word + 3 bits, then cs_n high → rx_count = 1, frame_error = 1, frame_done pulses.
- Reset mid-frame after 12 bits, cs_n held low through reset release, then 8 more clocks → no word_valid and no frame_done until a fresh cs_n fall.
- WORD_W=16, DEPTH=2: send 0x1234, 0xBEEF → rx_data = 0xBEEF_1234. Next frame sends 1 word → rx_count = 1, rx_data[31:16] retains 0xBEEF.
